// File: rtl/fifo_ctrl_sync.sv
// Single-clock FIFO controller: pointers, occupancy and status flags for a dual-port RAM with registered read.
// Optional almost_full/almost_empty watermark outputs are built when FIFO_CTRL_WATERMARK_EN is defined.
module fifo_ctrl_sync #(
    parameter int FIFO_DEPTH          = 256,
    parameter int ADDR_WIDTH          = 8,
    parameter int ALMOST_FULL_THRESH  = 192,
    parameter int ALMOST_EMPTY_THRESH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    output logic                  wr_full,
    input  logic                  rd_en,
    output logic                  rd_empty,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic                  underflow,
`ifdef FIFO_CTRL_WATERMARK_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr
);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]     count_reg, count_next;
    logic                    wr_full_reg;
    logic                    rd_empty_reg;
    logic                    rd_valid_reg;
    logic                    overflow_reg;
    logic                    underflow_reg;
    logic                    wr_acc;
    logic                    rd_acc;

    assign wr_acc = wr_en & ~wr_full_reg;
    assign rd_acc = rd_en & ~rd_empty_reg;

    // Explicit wrap compare so any depth works, not only powers of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_acc) begin
            wr_ptr_next = (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_next = (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= EMPTY;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            wr_full_reg   <= 1'b0;
            rd_empty_reg  <= 1'b1;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            rd_valid_reg  <= rd_acc;
            overflow_reg  <= wr_en & wr_full_reg;
            underflow_reg <= rd_en & rd_empty_reg;
            case (state_reg)
                EMPTY: begin
                    if (wr_acc) begin
                        state_reg    <= PARTIAL;
                        rd_empty_reg <= 1'b0;
                    end
                end
                PARTIAL: begin
                    if (count_next == DEPTH_CNT) begin
                        state_reg   <= FULL;
                        wr_full_reg <= 1'b1;
                    end else if (count_next == '0) begin
                        state_reg    <= EMPTY;
                        rd_empty_reg <= 1'b1;
                    end
                end
                FULL: begin
                    if (rd_acc) begin
                        state_reg   <= PARTIAL;
                        wr_full_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= EMPTY;
                    wr_full_reg  <= 1'b0;
                    rd_empty_reg <= 1'b1;
                end
            endcase
        end
    end

`ifdef FIFO_CTRL_WATERMARK_EN
    logic almost_full_reg;
    logic almost_empty_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
        end else begin
            almost_full_reg  <= (count_next >= (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH));
            almost_empty_reg <= (count_next <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH));
        end
    end

    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
`endif

    assign wr_full     = wr_full_reg;
    assign rd_empty    = rd_empty_reg;
    assign rd_valid    = rd_valid_reg;
    assign data_count  = count_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign mem_wr_en   = wr_acc;
    assign mem_wr_addr = wr_ptr_reg;
    assign mem_rd_en   = rd_acc;
    assign mem_rd_addr = rd_ptr_reg;

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Directed bench for fifo_ctrl_sync at depth 5 with a registered-read memory model attached.
// Watermark checks are compiled in when FIFO_CTRL_WATERMARK_EN is defined.
module tb_fifo_ctrl_sync;

    localparam int DEPTH = 5;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic          rd_en;
    logic          wr_full;
    logic          rd_empty;
    logic          rd_valid;
    logic [AW:0]   data_count;
    logic          overflow;
    logic          underflow;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    logic [7:0] wdata;
    logic [7:0] rd_data;
    logic [7:0] mem [0:DEPTH-1];

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    fifo_ctrl_sync #(
        .FIFO_DEPTH         (DEPTH),
        .ADDR_WIDTH         (AW),
        .ALMOST_FULL_THRESH (4),
        .ALMOST_EMPTY_THRESH(1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_full     (wr_full),
        .rd_en       (rd_en),
        .rd_empty    (rd_empty),
        .rd_valid    (rd_valid),
        .data_count  (data_count),
        .overflow    (overflow),
        .underflow   (underflow),
`ifdef FIFO_CTRL_WATERMARK_EN
        .almost_full (almost_full),
        .almost_empty(almost_empty),
`endif
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr)
    );

    // Generic dual-port memory with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= wdata;
        if (mem_rd_en) rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rstn  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Drive one write, check the memory request, then the post-edge count.
    task automatic wr_step(input int addr, input logic [7:0] d, input int cnt_after);
        wr_en = 1'b1;
        rd_en = 1'b0;
        wdata = d;
        #1;
        chk("wr_en_gate", int'(mem_wr_en), 1);
        chk("wr_addr", int'(mem_wr_addr), addr);
        tick();
        wr_en = 1'b0;
        chk("wr_count", int'(data_count), cnt_after);
    endtask

    task automatic rd_step(input int addr, input logic [7:0] d, input int cnt_after);
        rd_en = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("rd_en_gate", int'(mem_rd_en), 1);
        chk("rd_addr", int'(mem_rd_addr), addr);
        tick();
        rd_en = 1'b0;
        chk("rd_valid", int'(rd_valid), 1);
        chk("rd_data", int'(rd_data), int'(d));
        chk("rd_count", int'(data_count), cnt_after);
    endtask

    initial begin
        wdata = 8'h00;
        do_reset();

        // Reset / idle state
        chk("rst_empty", int'(rd_empty), 1);
        chk("rst_full", int'(wr_full), 0);
        chk("rst_count", int'(data_count), 0);
        chk("rst_mwr", int'(mem_wr_en), 0);
        chk("rst_mrd", int'(mem_rd_en), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);
`ifdef FIFO_CTRL_WATERMARK_EN
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_af", int'(almost_full), 0);
`endif

        // Fill to full
        for (int i = 0; i < 5; i++) begin
            wr_step(i, 8'hA0 + 8'(i), i + 1);
            chk("fill_empty", int'(rd_empty), 0);
`ifdef FIFO_CTRL_WATERMARK_EN
            chk("fill_ae", int'(almost_empty), (i + 1 <= 1) ? 1 : 0);
            chk("fill_af", int'(almost_full), (i + 1 >= 4) ? 1 : 0);
`endif
            if (i < 4) chk("fill_notfull", int'(wr_full), 0);
        end
        chk("full_flag", int'(wr_full), 1);

        // Write while full: rejected, overflow pulses for one cycle
        wr_en = 1'b1;
        #1;
        chk("ovf_gate", int'(mem_wr_en), 0);
        tick();
        wr_en = 1'b0;
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_count", int'(data_count), 5);
        tick();
        chk("ovf_clear", int'(overflow), 0);

        // Drain, data must match the fill pattern
        for (int i = 0; i < 5; i++) begin
            rd_step(i, 8'hA0 + 8'(i), 4 - i);
            chk("drain_full", int'(wr_full), 0);
        end
        chk("drain_empty", int'(rd_empty), 1);
        tick();
        chk("valid_drop", int'(rd_valid), 0);

        // Read while empty: rejected, underflow pulse
        rd_en = 1'b1;
        #1;
        chk("udf_gate", int'(mem_rd_en), 0);
        tick();
        rd_en = 1'b0;
        chk("udf_pulse", int'(underflow), 1);
        chk("udf_valid", int'(rd_valid), 0);
        chk("udf_count", int'(data_count), 0);

        // Wrap-around from a fresh reset
        do_reset();
        for (int i = 0; i < 3; i++) wr_step(i, 8'hB0 + 8'(i), i + 1);
        for (int i = 0; i < 3; i++) rd_step(i, 8'hB0 + 8'(i), 2 - i);
        for (int i = 0; i < 4; i++) wr_step((3 + i) % 5, 8'hC0 + 8'(i), i + 1);
        chk("wrap_peak", int'(data_count), 4);
        for (int i = 0; i < 4; i++) rd_step((3 + i) % 5, 8'hC0 + 8'(i), 3 - i);
        // Pointers now both at 2, FIFO empty

        // Simultaneous access while empty: write only
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hD0;
        #1;
        chk("se_wr", int'(mem_wr_en), 1);
        chk("se_rd", int'(mem_rd_en), 0);
        tick();
        chk("se_count", int'(data_count), 1);
        chk("se_udf", int'(underflow), 1);
        chk("se_valid", int'(rd_valid), 0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_step(3, 8'hD1, 2);

        // Simultaneous access with count 2: both accepted, count holds
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hD2;
        #1;
        chk("sp_wr", int'(mem_wr_en), 1);
        chk("sp_rd", int'(mem_rd_en), 1);
        chk("sp_wr_addr", int'(mem_wr_addr), 4);
        chk("sp_rd_addr", int'(mem_rd_addr), 2);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("sp_count", int'(data_count), 2);
        chk("sp_valid", int'(rd_valid), 1);
        chk("sp_data", int'(rd_data), 8'hD0);
        chk("sp_wr_next", int'(mem_wr_addr), 0);
        chk("sp_rd_next", int'(mem_rd_addr), 3);

        // Top up to full, then simultaneous access: read only
        for (int i = 0; i < 3; i++) wr_step(i, 8'hE0 + 8'(i), 3 + i);
        chk("sf_full", int'(wr_full), 1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        chk("sf_wr", int'(mem_wr_en), 0);
        chk("sf_rd", int'(mem_rd_en), 1);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("sf_count", int'(data_count), 4);
        chk("sf_ovf", int'(overflow), 1);
        chk("sf_notfull", int'(wr_full), 0);
        chk("sf_data", int'(rd_data), 8'hD1);

        // Asynchronous reset mid-operation, checked before the next clock edge
        rd_en = 1'b1;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("ar_count", int'(data_count), 0);
        chk("ar_empty", int'(rd_empty), 1);
        chk("ar_full", int'(wr_full), 0);
        chk("ar_valid", int'(rd_valid), 0);
        chk("ar_rd_addr", int'(mem_rd_addr), 0);
        chk("ar_wr_addr", int'(mem_wr_addr), 0);
`ifdef FIFO_CTRL_WATERMARK_EN
        chk("ar_ae", int'(almost_empty), 1);
        chk("ar_af", int'(almost_full), 0);
`endif
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_cnt", int'(data_count), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
